shift_reg_univ: RTL

- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register with complementary output.
- Adds synchronous reset, clock enable, parallel load, left/right shift and an auto serial-transfer sequencer that shifts the whole word out LSB-first.
- Used as the general-purpose storage/serializer element in lab datapaths; one instance replaces a bank of d_flip_flop cells plus glue.

---
 rtl/shift_reg_univ_if.sv | 27 ++
 rtl/shift_reg_univ.sv | 96 +++++++++
 2 files changed

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle for shift_reg_univ: the driver side uses master, the register uses slave.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_hi;
    logic             sin_lo;
    logic             rot;
    logic             start;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] notq;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, d, sin_hi, sin_lo, rot, start,
        input  q, notq, sout, busy, done
    );

    modport slave (
        input  en, mode, d, sin_hi, sin_lo, rot, start,
        output q, notq, sout, busy, done
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register with parallel load and an LSB-first auto serial transfer.
// Optional rotate fill is compiled in when SHIFT_REG_UNIV_ROTATE_EN is defined.
module shift_reg_univ #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_reg_univ_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state = IDLE;
    logic [CW-1:0]    cnt   = '0;
    logic [WIDTH-1:0] q     = INIT;
    logic             busy  = 1'b0;
    logic             done  = 1'b0;

    logic             fill_hi;
    logic             fill_lo;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] shl;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    // Rotate takes the fill bit from the opposite end of the word instead of the serial pins.
    assign fill_hi = bus.rot ? q[0]       : bus.sin_hi;
    assign fill_lo = bus.rot ? q[WIDTH-1] : bus.sin_lo;
`else
    logic unused_rot;
    assign unused_rot = bus.rot;
    assign fill_hi    = bus.sin_hi;
    assign fill_lo    = bus.sin_lo;
`endif

    assign shr = {fill_hi, q[WIDTH-1:1]};
    assign shl = {q[WIDTH-2:0], fill_lo};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= INIT;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (bus.en) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= XFER;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        case (bus.mode)
                            2'b01:   q <= shr;
                            2'b10:   q <= shl;
                            2'b11:   q <= bus.d;
                            default: q <= q;
                        endcase
                    end
                end
                XFER: begin
                    // The final shift happens on the same edge that moves to DONE.
                    q   <= shr;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q    = q;
    assign bus.notq = ~q;
    assign bus.sout = q[0];
    assign bus.busy = busy;
    assign bus.done = done;
endmodule
